// File: rtl/task_call_sched.sv
// Round-robin scheduler for a shared two-phase "task call" unit: d follows b at grant,
// c follows a after PH1_CYC cycles, and the completion counter ticks PH2_CYC cycles later.
module task_call_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned W       = 32,
    parameter int unsigned CW      = 32,
    parameter int unsigned PH1_CYC = 10,
    parameter int unsigned PH2_CYC = 10,
    localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ-1:0]   b_in,
    input  logic              abort,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [W-1:0]      c_out,
    output logic              d_out,
    output logic [CW-1:0]     count,
    output logic              done,
    output logic              aborted,
    output logic [IW-1:0]     owner_id
);

    localparam int unsigned TMAX = (PH1_CYC > PH2_CYC) ? PH1_CYC : PH2_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPh1  = 2'd1,
        StPh2  = 2'd2,
        StRet  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [W-1:0]    a_lat_q, a_lat_d;
    logic [W-1:0]    c_q, c_d;
    logic            d_q, d_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic            rr_found;
    logic [IW-1:0]   rr_idx;
    logic [IW-1:0]   rr_win;
    logic [W-1:0]    a_sel;

    // Search starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_win   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_idx = IW'((32'(ptr_q) + k) % NREQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
        a_sel = a_in[32'(rr_win) * W +: W];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        a_lat_d   = a_lat_q;
        c_d       = c_q;
        d_d       = d_q;
        count_d   = count_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        owner_d   = owner_q;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    ptr_d          = rr_win;
                    owner_d        = rr_win;
                    a_lat_d        = a_sel;
                    d_d            = b_in[rr_win];
                    gnt_d          = '0;
                    gnt_d[rr_win]  = 1'b1;
                    timer_d        = TW'(PH1_CYC - 1);
                    state_d        = StPh1;
                end
            end
            StPh1: begin
                // Abort wins over the terminal count, so c is left as it was.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StRet;
                end else if (timer_q == '0) begin
                    c_d     = a_lat_q;
                    timer_d = TW'(PH2_CYC - 1);
                    state_d = StPh2;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StPh2: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StRet;
                end else if (timer_q == '0) begin
                    count_d = count_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = StRet;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRet: begin
                // req is ignored here so the owner has a cycle to drop it.
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= IW'(NREQ - 1);
            timer_q   <= '0;
            a_lat_q   <= '0;
            c_q       <= '0;
            d_q       <= 1'b0;
            count_q   <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            a_lat_q   <= a_lat_d;
            c_q       <= c_d;
            d_q       <= d_d;
            count_q   <= count_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            owner_q   <= owner_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != StIdle);
    assign c_out    = c_q;
    assign d_out    = d_q;
    assign count    = count_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign owner_id = owner_q;

endmodule

// File: tb/tb_task_call_sched.sv
// Bench for task_call_sched: transaction-level model predicts winner, output update
// cycles and counter value per call; every cycle of each call is compared.
module tb_task_call_sched;

    localparam int unsigned NREQ = 3;
    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 8;
    localparam int unsigned PH1  = 10;
    localparam int unsigned PH2  = 10;
    localparam int unsigned IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ-1:0]   b_in;
    logic              abort;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [W-1:0]      c_out;
    logic              d_out;
    logic [CW-1:0]     count;
    logic              done;
    logic              aborted;
    logic [IW-1:0]     owner_id;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            m_ptr;
    logic [W-1:0]  m_c;
    logic          m_d;
    logic [CW-1:0] m_count;

    always #5 clk = ~clk;

    task_call_sched #(
        .NREQ    (NREQ),
        .W       (W),
        .CW      (CW),
        .PH1_CYC (PH1),
        .PH2_CYC (PH2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .abort    (abort),
        .gnt      (gnt),
        .busy     (busy),
        .c_out    (c_out),
        .d_out    (d_out),
        .count    (count),
        .done     (done),
        .aborted  (aborted),
        .owner_id (owner_id)
    );

    task automatic model_reset();
        m_ptr   = NREQ - 1;
        m_c     = '0;
        m_d     = 1'b0;
        m_count = '0;
    endtask

    function automatic logic [NREQ*W-1:0] rand_a();
        logic [NREQ*W-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge after the first IDLE edge.
    task automatic run_call(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] a_vals,
                            input logic [NREQ-1:0] b_vals, input int abort_k,
                            input bit idle_abort, input bit ret_abort, input bit scramble,
                            output int busy_n);
        int            win;
        int            end_k;
        bit            ab_call;
        logic [W-1:0]  a_l;
        logic [NREQ-1:0] e_gnt;
        logic [IW-1:0] e_own;
        logic          e_busy, e_done, e_ab;
        req   = mask;
        a_in  = a_vals;
        b_in  = b_vals;
        abort = idle_abort;
        win   = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && mask[idx]) win = idx;
        end
        m_ptr   = win;
        m_d     = b_vals[win];
        a_l     = a_vals[win*W +: W];
        e_own   = IW'(win);
        ab_call = (abort_k >= 1) && (abort_k <= PH1 + PH2);
        end_k   = ab_call ? abort_k : PH1 + PH2;
        busy_n  = 0;
        for (int k = 0; k <= end_k + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == PH1 && !(ab_call && abort_k <= PH1)) m_c = a_l;
            if (k == PH1 + PH2 && !ab_call) m_count = m_count + 1'b1;
            e_busy = (k <= end_k);
            e_gnt  = (k <= end_k) ? NREQ'(1 << win) : '0;
            e_done = (k == end_k) && !ab_call;
            e_ab   = (k == end_k) && ab_call;
            if (busy) busy_n++;
            checks++;
            if (busy !== e_busy) begin
                failures++;
                $display("FAIL busy k=%0d got=%b exp=%b", k, busy, e_busy);
            end
            checks++;
            if (gnt !== e_gnt) begin
                failures++;
                $display("FAIL gnt k=%0d got=%b exp=%b", k, gnt, e_gnt);
            end
            checks++;
            if (owner_id !== e_own) begin
                failures++;
                $display("FAIL owner_id k=%0d got=%0d exp=%0d", k, owner_id, e_own);
            end
            checks++;
            if (c_out !== m_c) begin
                failures++;
                $display("FAIL c_out k=%0d got=%h exp=%h", k, c_out, m_c);
            end
            checks++;
            if (d_out !== m_d) begin
                failures++;
                $display("FAIL d_out k=%0d got=%b exp=%b", k, d_out, m_d);
            end
            checks++;
            if (count !== m_count) begin
                failures++;
                $display("FAIL count k=%0d got=%h exp=%h", k, count, m_count);
            end
            checks++;
            if (done !== e_done) begin
                failures++;
                $display("FAIL done k=%0d got=%b exp=%b", k, done, e_done);
            end
            checks++;
            if (aborted !== e_ab) begin
                failures++;
                $display("FAIL aborted k=%0d got=%b exp=%b", k, aborted, e_ab);
            end
            if (k <= end_k) begin
                abort = (k + 1 == abort_k) || (ret_abort && k == end_k);
                if (scramble) begin
                    a_in = rand_a();
                    b_in = NREQ'($urandom);
                    req  = NREQ'($urandom);
                end
            end
        end
        abort = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, busy, c_out, d_out, count, done, aborted, owner_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b busy=%b c=%h d=%b cnt=%h dn=%b ab=%b own=%0d exp=all zero",
                     gnt, busy, c_out, d_out, count, done, aborted, owner_id);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            failures++;
            $display("FAIL idle_no_req got busy=%b gnt=%b exp busy=0 gnt=0", busy, gnt);
        end
    endtask

    task automatic test_single_call();
        int bn;
        logic [NREQ*W-1:0] av;
        av = '0;
        av[W-1:0] = 32'hFFFF_FFFF;
        run_call(3'b001, av, 3'b001, 15, 1'b0, 1'b0, 1'b0, bn);
        av = '0;
        run_call(3'b001, av, 3'b000, -1, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (c_out !== 32'h0 || count !== 8'd1) begin
            failures++;
            $display("FAIL single_call got c=%h cnt=%h exp c=00000000 cnt=01", c_out, count);
        end
    endtask

    task automatic test_back_to_back();
        int bn;
        logic [NREQ*W-1:0] av;
        av = '0;
        av[W-1:0] = 32'd1;
        run_call(3'b001, av, 3'b001, 5, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (c_out !== 32'h0 || d_out !== 1'b1 || count !== 8'd1) begin
            failures++;
            $display("FAIL b2b_abort got c=%h d=%b cnt=%h exp c=0 d=1 cnt=1", c_out, d_out, count);
        end
        av[W-1:0] = 32'd2;
        run_call(3'b001, av, 3'b000, -1, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (c_out !== 32'h2 || d_out !== 1'b0 || count !== 8'd2) begin
            failures++;
            $display("FAIL b2b_done got c=%h d=%b cnt=%h exp c=2 d=0 cnt=2", c_out, d_out, count);
        end
    endtask

    task automatic test_alternate();
        int bn;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_call(3'b011, rand_a(), NREQ'($urandom), -1, 1'b0, 1'b0, 1'b0, bn);
            checks++;
            if (owner_id !== IW'(i % 2) || bn != 21) begin
                failures++;
                $display("FAIL alternate call=%0d got own=%0d busy_cycles=%0d exp own=%0d busy_cycles=21",
                         i, owner_id, bn, i % 2);
            end
        end
    endtask

    task automatic test_abort_terminal();
        int bn;
        logic [W-1:0]  c_before;
        logic [CW-1:0] n_before;
        c_before = c_out;
        run_call(3'b100, rand_a(), NREQ'($urandom), PH1, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (c_out !== c_before) begin
            failures++;
            $display("FAIL abort_ph1_edge got c=%h exp c=%h", c_out, c_before);
        end
        n_before = count;
        run_call(3'b010, rand_a(), NREQ'($urandom), PH1 + PH2, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (count !== n_before) begin
            failures++;
            $display("FAIL abort_ph2_edge got cnt=%h exp cnt=%h", count, n_before);
        end
    endtask

    task automatic test_reset_mid_call();
        int bn;
        req   = 3'b010;
        a_in  = rand_a();
        b_in  = 3'b010;
        abort = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gnt === '0) begin
            failures++;
            $display("FAIL mid_call_busy got busy=%b gnt=%b exp busy=1 gnt!=0", busy, gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, c_out, d_out, count, done, aborted, owner_id} !== '0) begin
            failures++;
            $display("FAIL async_reset got gnt=%b busy=%b c=%h d=%b cnt=%h dn=%b ab=%b own=%0d exp=all zero",
                     gnt, busy, c_out, d_out, count, done, aborted, owner_id);
        end
        req = '1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL in_reset got dn=%b ab=%b busy=%b exp 0 0 0", done, aborted, busy);
            end
        end
        rst_n = 1'b1;
        model_reset();
        run_call('1, rand_a(), NREQ'($urandom), -1, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (owner_id !== '0) begin
            failures++;
            $display("FAIL post_reset_owner got own=%0d exp own=0", owner_id);
        end
    endtask

    task automatic test_random();
        int bn;
        int ak;
        for (int i = 0; i < 30; i++) begin
            ak = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(1, PH1 + PH2));
            run_call(NREQ'($urandom_range(1, (1 << NREQ) - 1)), rand_a(), NREQ'($urandom), ak,
                     $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b1, bn);
        end
    endtask

    task automatic test_count_wrap();
        int bn;
        for (int i = 0; i < 300 && m_count != 8'hFF; i++)
            run_call(NREQ'($urandom_range(1, (1 << NREQ) - 1)), rand_a(), NREQ'($urandom), -1,
                     1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (count !== 8'hFF) begin
            failures++;
            $display("FAIL count_preset got cnt=%h exp cnt=ff", count);
        end
        run_call(3'b001, rand_a(), NREQ'($urandom), -1, 1'b0, 1'b0, 1'b0, bn);
        checks++;
        if (count !== 8'h00) begin
            failures++;
            $display("FAIL count_wrap got cnt=%h exp cnt=00", count);
        end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_back_to_back();
        test_alternate();
        test_abort_terminal();
        test_reset_mid_call();
        test_random();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/task_call_sched.md
Name: task_call_sched

Overview:
- Synthesizable scheduler for a shared two-phase "task call" unit, modelled on a Verilog task with inputs a/b, outputs c/d and a side-effect counter.
- NREQ requesters compete round-robin for the unit.
- The granted call runs: d <= b immediately, c <= a after PH1_CYC cycles, count increments PH2_CYC cycles later.
- An abort input models "disable": it kills the in-flight call and leaves partial outputs in place.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 32, width of a / c
CW, 32, width of completion counter
PH1_CYC, 10, cycles from grant edge to c update (>=1)
PH2_CYC, 10, cycles from c update to count increment (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester call request, held until its done or aborted
a_in  in  NREQ*W  per-requester a operand, slice i = requester i
b_in  in  NREQ  per-requester b operand
abort  in  1  disable the in-flight call
gnt  out  NREQ  one-hot, identifies the owner of the current call
busy  out  1  high in PH1, PH2 and RET
c_out  out  W  task output c
d_out  out  1  task output d
count  out  CW  completed-call counter
done  out  1  one-cycle pulse: call completed
aborted  out  1  one-cycle pulse: call was disabled
owner_id  out  clog2(NREQ)  index of the current or last owner

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, busy=0, c_out=0, d_out=0, count=0, done=0, aborted=0, owner_id=0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - Asserting reset mid-call discards the call: no done, no aborted, no count change.
- States: IDLE, PH1, PH2, RET.
- IDLE, any req bit set, at edge E0:
  - Pick the first set bit searching from pointer+1 with wrap; pointer <= winner.
  - Latch a_in slice into a_lat; d_out <= b_in[winner]; gnt <= onehot(winner); owner_id <= winner.
  - timer <= PH1_CYC-1; state <= PH1.
- PH1:
  - abort=1: state <= RET, aborted <= 1; c_out unchanged.
  - Else if timer==0: c_out <= a_lat, timer <= PH2_CYC-1, state <= PH2.
  - Else timer decrements.
  - c_out therefore updates at edge E0+PH1_CYC.
- PH2:
  - abort=1: state <= RET, aborted <= 1; count unchanged.
  - Else if timer==0: count <= count+1 (wraps modulo 2^CW), done <= 1, state <= RET.
  - Else timer decrements.
  - count updates at edge E0+PH1_CYC+PH2_CYC.
- RET (exactly one cycle):
  - done or aborted high, gnt still held.
  - At exit: done, aborted, gnt <= 0; state <= IDLE.
  - req is ignored in RET, so the owner has one cycle to drop req.
- Earliest next grant is the edge after the first IDLE cycle begins.
- Abort priority:
  - abort on the same edge as the PH1 or PH2 terminal count wins: no c or count update, aborted=1, done=0.
  - abort in IDLE or RET is ignored.
- Outputs c_out and d_out hold their values between calls and after abort; they are not cleared.
- Requester rules:
  - a_in and b_in are sampled only at the grant edge; later changes have no effect.
  - req dropped by a non-owner mid-call has no effect.
  - req dropped by the owner mid-call does not cancel; only abort cancels.
- done and aborted are never both 1. gnt is zero or one-hot at all times.

Test Plan:
1. Reset, then req=01, a0=0, b0=0, c_out preset by prior call to FFFFFFFF: d_out=0 after E0; c_out=00000000 at E0+10; count=1 and done=1 at E0+20; RET, then IDLE.
2. Back-to-back calls from requester 0 (a0=0 b0=0, then a0=1 b0=1, then a0=2 b0=0):
   - With abort pulsed 5 cycles after the second grant: second call aborted=1, d_out=1, c_out stays 0, count stays 1.
   - Third call completes with c_out=2, d_out=0, count=2.
3. req=11 held continuously: grants alternate 0,1,0,1; owner_id sequence 0,1,0,1; each call spans 21 busy cycles plus one IDLE cycle.
4. Abort on exactly the PH1 terminal edge (E0+10): c_out unchanged, aborted=1, done=0. Repeat at E0+20: count unchanged.
5. rst_n pulsed low asynchronously mid-PH2: all outputs 0 immediately, no done or aborted pulse; the next req is granted to requester 0.
6. count preset to FFFFFFFF via 2^32-1 completions (forced), then one more completion: count=00000000, done=1.
